// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals between a program source and imem_loader.
// The master drives the byte stream; the slave (the loader) drives the memory write port and status.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] loaded_words;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error, loaded_words
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error, loaded_words
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills the instruction memory and holds the core in reset until done.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 32
) (
  input  logic clk,
  input  logic reset,
  imem_loader_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_END = ST_CHK;
`else
  localparam logic [2:0] ST_END = ST_DONE;
`endif

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] lane_p0;
  logic [15:0] words;
  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = bus.in_valid && bus.in_ready;
  assign len_full  = {bus.in_data, len_lo};
  assign last_word = ((words + 16'd1) == len);

  // Stage p0: byte capture and framing; stage p1: registered memory write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      len_lo   <= 8'd0;
      len      <= 16'd0;
      byte_idx <= 2'd0;
      lane_p0  <= 24'd0;
      words    <= 16'd0;
      vld_p1   <= 1'b0;
      addr_p1  <= BASE_ADDR;
      wdata_p1 <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= 8'd0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (bus.in_data == SYNC) begin
              state <= ST_LEN_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum   <= 8'd0;
`endif
            end
          end
          ST_LEN_LO: begin
            len_lo <= bus.in_data;
            state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len <= len_full;
            if (len_full > MAX_LEN) begin
              state <= ST_ERROR;
            end else if (len_full == 16'd0) begin
              state <= ST_END;
            end else begin
              state    <= ST_DATA;
              words    <= 16'd0;
              byte_idx <= 2'd0;
            end
          end
          ST_DATA: begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + bus.in_data;
`endif
            case (byte_idx)
              2'd0: lane_p0[7:0]   <= bus.in_data;
              2'd1: lane_p0[15:8]  <= bus.in_data;
              2'd2: lane_p0[23:16] <= bus.in_data;
              default: begin
                // Address uses the pre-increment word count.
                vld_p1   <= 1'b1;
                wdata_p1 <= {bus.in_data, lane_p0};
                addr_p1  <= BASE_ADDR + {14'd0, words, 2'b00};
                words    <= words + 16'd1;
                if (last_word) state <= ST_END;
              end
            endcase
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          ST_CHK: state <= (bus.in_data == sum) ? ST_DONE : ST_ERROR;
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = (state != ST_ERROR);
  assign bus.core_hold    = (state != ST_DONE);
  assign bus.done         = (state == ST_DONE);
  assign bus.error        = (state == ST_ERROR);
  assign bus.loaded_words = words;
  assign bus.imem_we      = vld_p1;
  assign bus.imem_addr    = addr_p1;
  assign bus.imem_wdata   = wdata_p1;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued as frames are sent
// and matched against every imem_we pulse.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXW = 32;

  logic clk;
  logic reset;
  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [63:0] sb[$];
  logic [31:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && bus.imem_we === 1'b1) begin
      logic [63:0] e;
      wr_count++;
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("we_addr", bus.imem_addr, e[63:32]);
        chk("we_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the words in wq as a framed image; chk_adj corrupts the checksum when nonzero.
  task automatic frame(input logic [7:0] chk_adj, input bit gaps);
    logic [7:0]  s;
    logic [15:0] len;
    logic [31:0] w;
    s   = 8'd0;
    len = 16'(wq.size());
    send(8'hA5);
    send(len[7:0]);
    send(len[15:8]);
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      sb.push_back({BASE + 32'(4 * i), w});
      for (int k = 0; k < 4; k++) begin
        s = s + w[8*k +: 8];
        send(w[8*k +: 8]);
      end
      if (gaps) idle(2);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(s + chk_adj);
`endif
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int snap;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", bus.imem_addr, BASE);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_hold", 32'(bus.core_hold), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_loaded", 32'(bus.loaded_words), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Two-word image.
    wq = {32'h00000013, 32'h005200B3};
    frame(8'd0, 1'b0);
    chk("a_done", 32'(bus.done), 32'd1);
    chk("a_hold", 32'(bus.core_hold), 32'd0);
    chk("a_loaded", 32'(bus.loaded_words), 32'd2);
    idle(3);

    // Reload from DONE.
    send(8'hA5);
    chk("reload_hold", 32'(bus.core_hold), 32'd1);
    chk("reload_done", 32'(bus.done), 32'd0);
    send(8'h01);
    send(8'h00);
    sb.push_back({BASE, 32'hEFBEADDE});
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h38);
`endif
    chk("reload_done2", 32'(bus.done), 32'd1);
    chk("reload_loaded", 32'(bus.loaded_words), 32'd1);
    idle(3);

    // Leading garbage is discarded; gaps in the stream are legal.
    do_reset();
    snap = wr_count;
    send(8'h00); send(8'hFF); send(8'h7E);
    idle(1);
    chk("garb_error", 32'(bus.error), 32'd0);
    wq = {32'h44332211};
    frame(8'd0, 1'b1);
    idle(3);
    chk("garb_writes", 32'(wr_count - snap), 32'd1);
    chk("garb_done", 32'(bus.done), 32'd1);

    // Oversize frame goes to ERROR and stays there.
    do_reset();
    snap = wr_count;
    send(8'hA5); send(8'h21); send(8'h00);
    chk("big_error", 32'(bus.error), 32'd1);
    chk("big_ready", 32'(bus.in_ready), 32'd0);
    send(8'hA5); send(8'h01); send(8'h00);
    idle(3);
    chk("big_sticky", 32'(bus.error), 32'd1);
    chk("big_hold", 32'(bus.core_hold), 32'd1);
    chk("big_writes", 32'(wr_count - snap), 32'd0);
    do_reset();
    chk("big_cleared", 32'(bus.error), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: the write happens but the core stays held.
    wq = {32'h04030201};
    frame(8'd1, 1'b0);
    idle(2);
    chk("chk_error", 32'(bus.error), 32'd1);
    chk("chk_done", 32'(bus.done), 32'd0);
    chk("chk_hold", 32'(bus.core_hold), 32'd1);
    do_reset();
`endif

    // Reset mid-word drops the partial word; a fresh frame starts at BASE.
    snap = wr_count;
    send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_hold", 32'(bus.core_hold), 32'd1);
    chk("abort_loaded", 32'(bus.loaded_words), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wq = {32'h04030201};
    frame(8'd0, 1'b0);
    idle(3);
    chk("abort_writes", 32'(wr_count - snap), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
